exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
MEM-stage exception detector and prioritiser; the producer side of the CP0 exception interface.
- Collects per-instruction exception flags, the pipeline interrupt inputs and the live CP0 Status/Cause/EPC.
- Emits one exception code, the faulting PC, the delay-slot flag and the bad address to the CP0 register block in the same cycle.
- Drives pipeline flush and the redirect PC.
- Forwards an in-flight mtc0 in WB and suppresses wrong-path exceptions during the flush window.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception except eret
FLUSH_HOLD, 2, cycles after a taken exception during which new exceptions are masked (1..15)
SYNC_STAGES, 2, flop stages on the external interrupt lines (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
int_i  in  6  raw hardware interrupt lines
mem_valid_i  in  1  MEM holds a real instruction
mem_stall_i  in  1  MEM stalled this cycle
mem_pc_i  in  32  PC of MEM instruction
mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
mem_addr_i  in  32  data address of MEM load/store
exc_adel_if_i  in  1  fetch address misaligned
exc_ri_i  in  1  reserved instruction
exc_ov_i  in  1  ALU overflow
exc_trap_i  in  1  trap condition true
exc_sys_i  in  1  syscall
exc_bp_i  in  1  break
exc_adel_ld_i  in  1  load misaligned
exc_ades_st_i  in  1  store misaligned
exc_eret_i  in  1  eret
cp0_status_i  in  32  current Status
cp0_cause_i  in  32  current Cause
cp0_epc_i  in  32  current EPC
wb_cp0_we_i  in  1  mtc0 in WB writes CP0 this edge
wb_cp0_waddr_i  in  5  its CP0 register number
wb_cp0_data_i  in  32  its data
int_sync_o  out  6  synchronised interrupt lines (feeds CP0 int_i)
excepttype_o  out  32  exception code to CP0
exc_pc_o  out  32  faulting PC to CP0
exc_in_delayslot_o  out  1  delay-slot flag to CP0
bad_addr_o  out  32  BadVAddr value to CP0
flush_o  out  1  flush IF..MEM
newpc_o  out  32  redirect PC

Behaviour:
- Reset (rst=1 at posedge): sync chain cleared, int_sync_o=0, state IDLE, hold counter 0.
- Combinational outputs while rst=1: excepttype_o=0, flush_o=0, newpc_o=0, exc_pc_o=0, bad_addr_o=0, exc_in_delayslot_o=0.
- Interrupt sync: int_i passes through SYNC_STAGES flops; int_sync_o is the last stage.
- Forwarding:
  - eff_status = wb_cp0_data_i when wb_cp0_we_i and waddr=12, else cp0_status_i.
  - eff_epc = wb_cp0_data_i when wb_cp0_we_i and waddr=14, else cp0_epc_i.
  - eff_cause[9:8] = wb_cp0_data_i[9:8] when wb_cp0_we_i and waddr=13, else cp0_cause_i[9:8].
  - eff_cause[15:10] = cp0_cause_i[15:10].
- int_pending = eff_status[0] & ~eff_status[1] & |(eff_cause[15:8] & eff_status[15:8]).
- take = state==IDLE & mem_valid_i & ~mem_stall_i.
- Code selection when take, first match wins:
  - int_pending -> 0x01
  - exc_adel_if_i -> 0x04
  - exc_ri_i -> 0x0a
  - exc_ov_i -> 0x0c
  - exc_trap_i -> 0x0d
  - exc_sys_i -> 0x08
  - exc_bp_i -> 0x09
  - exc_adel_ld_i -> 0x04
  - exc_ades_st_i -> 0x05
  - exc_eret_i -> 0x0e
  - none -> 0
- When take is false, excepttype_o=0; stalled or masked cycles never write CP0.
- bad_addr_o = mem_pc_i for fetch AdEL; mem_addr_i for load/store AdEL/AdES; else 0.
- exc_pc_o = mem_pc_i and exc_in_delayslot_o = mem_in_delayslot_i whenever take; 0 otherwise.
- flush_o = (excepttype_o != 0), same cycle, zero latency.
- newpc_o = eff_epc for 0x0e; EXC_VECTOR for other nonzero codes; 0 when flush_o=0.
- FSM:
  - IDLE -> HOLD on a taken nonzero code; counter loads FLUSH_HOLD-1.
  - HOLD: flush_o=0, excepttype_o=0, counter decrements each cycle regardless of stall; at 0 -> IDLE.
  - Interrupts arriving during HOLD stay pending and are taken in IDLE.
- Stall on an excepting instruction: nothing issued; issued once on the first unstalled cycle.
- Reset during HOLD returns to IDLE next edge.

Test Plan:
- Syscall at pc=0xBFC00100, not delay slot, no stall -> excepttype_o=0x08, exc_pc_o=0xBFC00100, flush_o=1, newpc_o=0xBFC00380 same cycle; next 2 cycles excepttype_o=0 even with exc_sys_i held.
- Status=0x0000FF01, int_i[0]=1 -> after SYNC_STAGES cycles, next valid MEM instr yields code 0x01; same with Status[1]=1 -> no exception.
- exc_ri_i and exc_ov_i both set -> 0x0a; exc_adel_if_i at pc=0xBFC00002 plus exc_ri_i -> 0x04, bad_addr_o=0xBFC00002.
- Store misaligned, mem_addr_i=0x80000003, delay slot -> 0x05, bad_addr_o=0x80000003, exc_in_delayslot_o=1.
- eret with cp0_epc_i=0x100 while WB mtc0 writes EPC=0x200 -> newpc_o=0x200, code 0x0e.
- mem_stall_i=1 for 3 cycles on syscall -> excepttype_o=0 for 3 cycles, then 0x08 once; rst asserted in HOLD -> IDLE next cycle, outputs 0.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception detector and prioritiser.
// Resolves the highest-priority exception of the MEM instruction, presents it
// to CP0 in the same cycle, drives the pipeline flush/redirect and masks
// wrong-path exceptions for FLUSH_HOLD cycles after a taken exception.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int unsigned FLUSH_HOLD  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_st_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [3:0] HOLD_LOAD  = 4'(FLUSH_HOLD - 1);

  localparam logic [31:0] CODE_NONE = 32'h0000_0000;
  localparam logic [31:0] CODE_INT  = 32'h0000_0001;
  localparam logic [31:0] CODE_ADEL = 32'h0000_0004;
  localparam logic [31:0] CODE_ADES = 32'h0000_0005;
  localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
  localparam logic [31:0] CODE_BP   = 32'h0000_0009;
  localparam logic [31:0] CODE_RI   = 32'h0000_000A;
  localparam logic [31:0] CODE_OV   = 32'h0000_000C;
  localparam logic [31:0] CODE_TRAP = 32'h0000_000D;
  localparam logic [31:0] CODE_ERET = 32'h0000_000E;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Winning exception source; two sources share code 0x04 but differ in
  // which address is reported as BadVAddr, so the source is kept explicitly.
  typedef enum logic [3:0] {
    CS_NONE    = 4'd0,
    CS_INT     = 4'd1,
    CS_ADEL_IF = 4'd2,
    CS_RI      = 4'd3,
    CS_OV      = 4'd4,
    CS_TRAP    = 4'd5,
    CS_SYS     = 4'd6,
    CS_BP      = 4'd7,
    CS_ADEL_LD = 4'd8,
    CS_ADES_ST = 4'd9,
    CS_ERET    = 4'd10
  } cause_sel_t;

  // Interrupt is enabled (IE=1, EXL=0) and at least one unmasked IP bit set.
  function automatic logic int_pending_f(input logic [31:0] status,
                                         input logic [7:0]  ip);
    int_pending_f = status[0] & ~status[1] & (|(ip & status[15:8]));
  endfunction

  // Fixed priority: first asserted source in the list wins.
  function automatic cause_sel_t select_cause_f(
    input logic int_pend, input logic adel_if, input logic ri,
    input logic ov, input logic trap, input logic sys, input logic bp,
    input logic adel_ld, input logic ades_st, input logic eret);
    if (int_pend)     select_cause_f = CS_INT;
    else if (adel_if) select_cause_f = CS_ADEL_IF;
    else if (ri)      select_cause_f = CS_RI;
    else if (ov)      select_cause_f = CS_OV;
    else if (trap)    select_cause_f = CS_TRAP;
    else if (sys)     select_cause_f = CS_SYS;
    else if (bp)      select_cause_f = CS_BP;
    else if (adel_ld) select_cause_f = CS_ADEL_LD;
    else if (ades_st) select_cause_f = CS_ADES_ST;
    else if (eret)    select_cause_f = CS_ERET;
    else              select_cause_f = CS_NONE;
  endfunction

  logic [5:0]  sync_r [SYNC_STAGES];
  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  hold_cnt_r;
  logic [3:0]  hold_cnt_nxt_s;
  logic [31:0] eff_status_s;
  logic [31:0] eff_epc_s;
  logic [7:0]  eff_ip_s;
  logic        int_pending_s;
  logic        take_s;
  cause_sel_t  cause_s;
  logic [31:0] code_s;
  logic [31:0] cause_bad_s;
  logic        unused_bits_s;

  assign unused_bits_s = &{1'b0, cp0_cause_i[31:16], cp0_cause_i[7:0],
                           eff_status_s[31:16], eff_status_s[7:2]};

  // Interrupt synchroniser chain; the last stage feeds CP0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_r[i] <= 6'd0;
      end
    end else begin
      sync_r[0] <= int_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign int_sync_o = sync_r[SYNC_STAGES-1];

  // Forward an mtc0 retiring in WB so this cycle sees the CP0 value it writes.
  always_comb begin
    eff_status_s = cp0_status_i;
    eff_epc_s    = cp0_epc_i;
    eff_ip_s     = cp0_cause_i[15:8];
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS)) begin
      eff_status_s = wb_cp0_data_i;
    end else begin
      eff_status_s = cp0_status_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC)) begin
      eff_epc_s = wb_cp0_data_i;
    end else begin
      eff_epc_s = cp0_epc_i;
    end
    // Only the software IP bits are writable; hardware IP bits come from CP0.
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE)) begin
      eff_ip_s = {cp0_cause_i[15:10], wb_cp0_data_i[9:8]};
    end else begin
      eff_ip_s = cp0_cause_i[15:8];
    end
  end

  // Prioritise the MEM instruction's exception sources into a code and BadVAddr.
  always_comb begin
    int_pending_s = int_pending_f(eff_status_s, eff_ip_s);
    take_s        = (state_r == ST_IDLE) & mem_valid_i & ~mem_stall_i;
    cause_s       = select_cause_f(int_pending_s, exc_adel_if_i, exc_ri_i,
                                   exc_ov_i, exc_trap_i, exc_sys_i, exc_bp_i,
                                   exc_adel_ld_i, exc_ades_st_i, exc_eret_i);
    code_s        = CODE_NONE;
    cause_bad_s   = 32'h0000_0000;
    case (cause_s)
      CS_INT:     code_s = CODE_INT;
      CS_ADEL_IF: begin
        code_s      = CODE_ADEL;
        cause_bad_s = mem_pc_i;
      end
      CS_RI:      code_s = CODE_RI;
      CS_OV:      code_s = CODE_OV;
      CS_TRAP:    code_s = CODE_TRAP;
      CS_SYS:     code_s = CODE_SYS;
      CS_BP:      code_s = CODE_BP;
      CS_ADEL_LD: begin
        code_s      = CODE_ADEL;
        cause_bad_s = mem_addr_i;
      end
      CS_ADES_ST: begin
        code_s      = CODE_ADES;
        cause_bad_s = mem_addr_i;
      end
      CS_ERET:    code_s = CODE_ERET;
      default: begin
        code_s      = CODE_NONE;
        cause_bad_s = 32'h0000_0000;
      end
    endcase
  end

  // Drive CP0 report, flush and redirect; everything quiet in reset or when not taken.
  always_comb begin
    excepttype_o       = CODE_NONE;
    exc_pc_o           = 32'h0000_0000;
    exc_in_delayslot_o = 1'b0;
    bad_addr_o         = 32'h0000_0000;
    flush_o            = 1'b0;
    newpc_o            = 32'h0000_0000;
    if (rst) begin
      excepttype_o = CODE_NONE;
    end else if (take_s) begin
      excepttype_o       = code_s;
      exc_pc_o           = mem_pc_i;
      exc_in_delayslot_o = mem_in_delayslot_i;
      bad_addr_o         = cause_bad_s;
      flush_o            = (code_s != CODE_NONE);
      if (code_s == CODE_ERET) begin
        newpc_o = eff_epc_s;
      end else if (code_s != CODE_NONE) begin
        newpc_o = EXC_VECTOR;
      end else begin
        newpc_o = 32'h0000_0000;
      end
    end else begin
      excepttype_o = CODE_NONE;
    end
  end

  // Flush-window state register and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end

  // Next-state: enter HOLD after a taken exception, count down the mask window.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s && (code_s != CODE_NONE)) begin
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = HOLD_LOAD;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == 4'd0) begin
          state_nxt_s    = ST_IDLE;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        hold_cnt_nxt_s = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl.
module tb_exception_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  int_i;
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic        exc_adel_if_i;
  logic        exc_ri_i;
  logic        exc_ov_i;
  logic        exc_trap_i;
  logic        exc_sys_i;
  logic        exc_bp_i;
  logic        exc_adel_ld_i;
  logic        exc_ades_st_i;
  logic        exc_eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [5:0]  int_sync_o;
  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic        exc_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;

  int chk_cnt;
  int pass_cnt;

  localparam logic [31:0] VEC = 32'hBFC00380;

  exception_ctrl #(
    .EXC_VECTOR (32'hBFC00380),
    .FLUSH_HOLD (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .int_i             (int_i),
    .mem_valid_i       (mem_valid_i),
    .mem_stall_i       (mem_stall_i),
    .mem_pc_i          (mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_addr_i        (mem_addr_i),
    .exc_adel_if_i     (exc_adel_if_i),
    .exc_ri_i          (exc_ri_i),
    .exc_ov_i          (exc_ov_i),
    .exc_trap_i        (exc_trap_i),
    .exc_sys_i         (exc_sys_i),
    .exc_bp_i          (exc_bp_i),
    .exc_adel_ld_i     (exc_adel_ld_i),
    .exc_ades_st_i     (exc_ades_st_i),
    .exc_eret_i        (exc_eret_i),
    .cp0_status_i      (cp0_status_i),
    .cp0_cause_i       (cp0_cause_i),
    .cp0_epc_i         (cp0_epc_i),
    .wb_cp0_we_i       (wb_cp0_we_i),
    .wb_cp0_waddr_i    (wb_cp0_waddr_i),
    .wb_cp0_data_i     (wb_cp0_data_i),
    .int_sync_o        (int_sync_o),
    .excepttype_o      (excepttype_o),
    .exc_pc_o          (exc_pc_o),
    .exc_in_delayslot_o(exc_in_delayslot_o),
    .bad_addr_o        (bad_addr_o),
    .flush_o           (flush_o),
    .newpc_o           (newpc_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] code,
                            input logic [31:0] pc, input logic ds,
                            input logic [31:0] bad, input logic [31:0] npc);
    check_val({tag, ".code"},  excepttype_o, code);
    check_val({tag, ".pc"},    exc_pc_o, pc);
    check_val({tag, ".ds"},    {31'd0, exc_in_delayslot_o}, {31'd0, ds});
    check_val({tag, ".bad"},   bad_addr_o, bad);
    check_val({tag, ".flush"}, {31'd0, flush_o}, {31'd0, (code != 32'd0)});
    check_val({tag, ".newpc"}, newpc_o, npc);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    int_i              = 6'd0;
    mem_valid_i        = 1'b0;
    mem_stall_i        = 1'b0;
    mem_pc_i           = 32'h0;
    mem_in_delayslot_i = 1'b0;
    mem_addr_i         = 32'h0;
    exc_adel_if_i      = 1'b0;
    exc_ri_i           = 1'b0;
    exc_ov_i           = 1'b0;
    exc_trap_i         = 1'b0;
    exc_sys_i          = 1'b0;
    exc_bp_i           = 1'b0;
    exc_adel_ld_i      = 1'b0;
    exc_ades_st_i      = 1'b0;
    exc_eret_i         = 1'b0;
    cp0_status_i       = 32'h0;
    cp0_cause_i        = 32'h0;
    cp0_epc_i          = 32'h0;
    wb_cp0_we_i        = 1'b0;
    wb_cp0_waddr_i     = 5'd0;
    wb_cp0_data_i      = 32'h0;
  endtask

  // Clear stimulus and let any flush window expire.
  task automatic settle();
    clr();
    repeat (3) tick();
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    clr();
    rst = 1'b1;
    tick();
    tick();
    // Outputs forced quiet while in reset even with an excepting instruction.
    mem_valid_i = 1'b1;
    exc_sys_i   = 1'b1;
    mem_pc_i    = 32'h1234;
    #1;
    check_outs("rst", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    check_val("rst.sync", {26'd0, int_sync_o}, 32'h0);
    clr();
    tick();
    rst = 1'b0;
    tick();

    // Syscall, then the two-cycle mask window, then retaken.
    mem_valid_i = 1'b1;
    exc_sys_i   = 1'b1;
    mem_pc_i    = 32'hBFC00100;
    #1;
    check_outs("sys", 32'h08, 32'hBFC00100, 1'b0, 32'h0, VEC);
    tick();
    check_outs("hold1", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    check_outs("hold2", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    check_val("after_hold", excepttype_o, 32'h08);
    settle();

    // Invalid MEM slot never raises.
    exc_sys_i = 1'b1;
    #1;
    check_val("invalid", excepttype_o, 32'h0);
    settle();

    // Interrupt synchroniser latency.
    int_i = 6'b000001;
    tick();
    check_val("sync1", {26'd0, int_sync_o}, 32'h0);
    tick();
    check_val("sync2", {26'd0, int_sync_o}, 32'h1);
    cp0_cause_i  = 32'h0000_0400;
    cp0_status_i = 32'h0000_FF01;
    mem_valid_i  = 1'b1;
    mem_pc_i     = 32'h8000_0040;
    #1;
    check_outs("int", 32'h01, 32'h8000_0040, 1'b0, 32'h0, VEC);
    settle();

    // EXL set blocks interrupts.
    cp0_cause_i  = 32'h0000_0400;
    cp0_status_i = 32'h0000_FF03;
    mem_valid_i  = 1'b1;
    #1;
    check_val("int_exl", excepttype_o, 32'h0);
    check_val("int_exl.flush", {31'd0, flush_o}, 32'h0);
    // IM masks the line.
    cp0_status_i = 32'h0000_0001;
    #1;
    check_val("int_mask", excepttype_o, 32'h0);
    // Status forwarded from WB enables it.
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd12;
    wb_cp0_data_i  = 32'h0000_FF01;
    #1;
    check_val("int_fwd_status", excepttype_o, 32'h01);
    settle();

    // Software interrupt via forwarded Cause[9:8].
    cp0_status_i   = 32'h0000_0101;
    mem_valid_i    = 1'b1;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd13;
    wb_cp0_data_i  = 32'h0000_0100;
    #1;
    check_val("int_sw_fwd", excepttype_o, 32'h01);
    settle();

    // Hardware IP bits are not forwarded from WB.
    cp0_status_i   = 32'h0000_FF01;
    mem_valid_i    = 1'b1;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd13;
    wb_cp0_data_i  = 32'h0000_FC00;
    #1;
    check_val("int_hw_nofwd", excepttype_o, 32'h0);
    settle();

    // Interrupt arriving during HOLD is taken once back in IDLE.
    mem_valid_i = 1'b1;
    exc_sys_i   = 1'b1;
    #1;
    check_val("ih.sys", excepttype_o, 32'h08);
    tick();
    exc_sys_i    = 1'b0;
    cp0_cause_i  = 32'h0000_0400;
    cp0_status_i = 32'h0000_FF01;
    #1;
    check_val("ih.hold1", excepttype_o, 32'h0);
    tick();
    check_val("ih.hold2", excepttype_o, 32'h0);
    tick();
    check_val("ih.taken", excepttype_o, 32'h01);
    settle();

    // Priorities and BadVAddr selection.
    mem_valid_i = 1'b1;
    mem_pc_i    = 32'h8000_1000;
    mem_addr_i  = 32'h8000_2001;
    exc_ri_i    = 1'b1;
    exc_ov_i    = 1'b1;
    #1;
    check_outs("ri_ov", 32'h0A, 32'h8000_1000, 1'b0, 32'h0, VEC);
    settle();
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'hBFC00002;
    mem_addr_i    = 32'h8000_2001;
    exc_adel_if_i = 1'b1;
    exc_ri_i      = 1'b1;
    #1;
    check_outs("adel_if", 32'h04, 32'hBFC00002, 1'b0, 32'hBFC00002, VEC);
    settle();
    mem_valid_i   = 1'b1;
    exc_ov_i      = 1'b1;
    exc_trap_i    = 1'b1;
    #1;
    check_val("ov", excepttype_o, 32'h0C);
    settle();
    mem_valid_i   = 1'b1;
    exc_trap_i    = 1'b1;
    exc_sys_i     = 1'b1;
    #1;
    check_val("trap", excepttype_o, 32'h0D);
    settle();
    mem_valid_i   = 1'b1;
    exc_bp_i      = 1'b1;
    exc_adel_ld_i = 1'b1;
    #1;
    check_val("bp", excepttype_o, 32'h09);
    settle();
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h8000_3000;
    mem_addr_i    = 32'h8000_0001;
    exc_adel_ld_i = 1'b1;
    exc_ades_st_i = 1'b1;
    #1;
    check_outs("adel_ld", 32'h04, 32'h8000_3000, 1'b0, 32'h8000_0001, VEC);
    settle();

    // Store misaligned in a delay slot.
    mem_valid_i        = 1'b1;
    mem_pc_i           = 32'h8000_4004;
    mem_in_delayslot_i = 1'b1;
    mem_addr_i         = 32'h8000_0003;
    exc_ades_st_i      = 1'b1;
    exc_eret_i         = 1'b1;
    #1;
    check_outs("ades", 32'h05, 32'h8000_4004, 1'b1, 32'h8000_0003, VEC);
    settle();

    // eret with EPC forwarded from WB, and without.
    mem_valid_i    = 1'b1;
    mem_pc_i       = 32'h8000_5000;
    exc_eret_i     = 1'b1;
    cp0_epc_i      = 32'h0000_0100;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd14;
    wb_cp0_data_i  = 32'h0000_0200;
    #1;
    check_outs("eret_fwd", 32'h0E, 32'h8000_5000, 1'b0, 32'h0, 32'h0000_0200);
    settle();
    mem_valid_i    = 1'b1;
    exc_eret_i     = 1'b1;
    cp0_epc_i      = 32'h0000_0100;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd12;
    wb_cp0_data_i  = 32'h0000_0200;
    #1;
    check_val("eret_nofwd", newpc_o, 32'h0000_0100);
    settle();

    // Stall holds the exception back, then it issues exactly once.
    mem_valid_i = 1'b1;
    mem_stall_i = 1'b1;
    exc_sys_i   = 1'b1;
    mem_pc_i    = 32'h8000_6000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall.code", excepttype_o, 32'h0);
      check_val("stall.flush", {31'd0, flush_o}, 32'h0);
      tick();
    end
    mem_stall_i = 1'b0;
    #1;
    check_outs("unstall", 32'h08, 32'h8000_6000, 1'b0, 32'h0, VEC);
    tick();
    check_val("unstall.hold", excepttype_o, 32'h0);

    // Reset in HOLD: outputs quiet, IDLE on the next edge.
    rst = 1'b1;
    #1;
    check_outs("rst_hold", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check_val("rst_hold.idle", excepttype_o, 32'h08);
    settle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
